// File: rtl/pkt_buf_pkg.sv
// pkt_buf_pkg: shared types, default geometry and width helpers for the packet buffer
package pkt_buf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_SLOTS = 16;
  localparam int DEF_SLOT_WORDS = 64;
  function automatic int bv_w(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int id_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction
  function automatic int len_w(input int slot_words);
    return $clog2(slot_words + 1);
  endfunction
  function automatic int off_w(input int slot_words);
    return (slot_words > 1) ? $clog2(slot_words) : 1;
  endfunction
  // Descriptor fields are sized from the default geometry; keep these in step with the top
  localparam int DESC_LEN_W = len_w(DEF_SLOT_WORDS);
  localparam int DESC_BV_W = bv_w(DEF_DATA_W);
  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_e;
  typedef enum logic {R_IDLE, R_RUN} r_state_e;
  typedef struct packed {
    logic committed;
    logic [DESC_LEN_W-1:0] len;
    logic [DESC_BV_W-1:0] last_bv;
  } slot_desc_t;
endpackage

// File: rtl/pkt_buf_ram.sv
// pkt_buf_ram: simple dual-port synchronous RAM with one-cycle read latency
module pkt_buf_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pkt_buf_ctrl.sv
// pkt_buf_ctrl: slot-based packet buffer with free-slot allocation, oversize drop and read-by-ID
// Optional statistics counters are built when PKT_BUF_STATS_EN is defined.
module pkt_buf_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_WORDS = DEF_SLOT_WORDS,
  localparam int BV_W = bv_w(DATA_W),
  localparam int ID_W = id_w(NUM_SLOTS),
  localparam int LEN_W = len_w(SLOT_WORDS)
) (
  input  logic CLK,
  input  logic reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [BV_W-1:0] byte_valid,
  input  logic wen,
  input  logic w_last_pkt,
  output logic w_ready,
  output logic [ID_W-1:0] id_out,
  output logic id_valid,
  output logic w_drop,
  input  logic ren,
  input  logic [ID_W-1:0] r_id_in,
  output logic r_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [BV_W-1:0] r_byte_valid,
  output logic r_valid,
  output logic r_last_pkt,
  output logic r_err,
  output logic [31:0] stat_wr_pkts,
  output logic [31:0] stat_drop_pkts,
  output logic [31:0] stat_rd_pkts
);
  localparam int OFF_W = off_w(SLOT_WORDS);
  localparam int DEPTH = NUM_SLOTS * SLOT_WORDS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  slot_desc_t desc_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_q;
  logic [ID_W-1:0] w_slot, w_cur, alloc_id, r_slot, rd_slot;
  logic [LEN_W-1:0] w_cnt, commit_len, rd_len;
  logic [OFF_W-1:0] r_off, rd_off;
  logic [AW-1:0] waddr, raddr;
  logic [DATA_W-1:0] ram_q;
  logic any_free, w_acc, over, alloc_en, ram_we, commit, drop_done;
  logic r_acc, rd_issue, rd_last, rd_err;
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (free_q[i]) alloc_id = ID_W'(i);
  end
  assign any_free = |free_q;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_comb begin
    w_next = w_acc ? (w_last_pkt ? W_IDLE : (over || w_state == W_DROP) ? W_DROP : W_PKT) : w_state;
    r_next = rd_issue ? (rd_last ? R_IDLE : R_RUN) : r_state;
  end
  // Ready outputs are gated by the reset pin so every output reads 0 while reset is held
  always_comb begin
    w_ready = reset & ((w_state != W_IDLE) | any_free);
    w_acc = wen & w_ready;
    over = (w_state == W_PKT) & (w_cnt == LEN_W'(SLOT_WORDS));
    alloc_en = w_acc & (w_state == W_IDLE);
    ram_we = w_acc & (w_state != W_DROP) & !over;
    commit = ram_we & w_last_pkt;
    drop_done = w_acc & w_last_pkt & (over | (w_state == W_DROP));
    w_cur = (w_state == W_IDLE) ? alloc_id : w_slot;
    commit_len = w_cnt + LEN_W'(1);
    waddr = AW'(w_cur) * AW'(SLOT_WORDS) + AW'(w_cnt);
    r_ready = reset & (r_state == R_IDLE);
    r_acc = ren & r_ready;
    rd_slot = (r_state == R_IDLE) ? r_id_in : r_slot;
    rd_off = (r_state == R_IDLE) ? '0 : r_off;
    rd_issue = (r_acc & desc_q[r_id_in].committed) | (r_state == R_RUN);
    rd_err = r_acc & !desc_q[r_id_in].committed;
    rd_len = desc_q[rd_slot].len;
    rd_last = rd_issue & (LEN_W'(rd_off) + LEN_W'(1) == rd_len);
    raddr = AW'(rd_slot) * AW'(SLOT_WORDS) + AW'(rd_off);
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      free_q <= '1;
      for (int i = 0; i < NUM_SLOTS; i++) desc_q[i] <= '0;
      w_slot <= '0;
      w_cnt <= '0;
      r_slot <= '0;
      r_off <= '0;
      id_out <= '0;
      id_valid <= 1'b0;
      w_drop <= 1'b0;
      r_valid <= 1'b0;
      r_last_pkt <= 1'b0;
      r_byte_valid <= '0;
      r_err <= 1'b0;
    end else begin
      if (alloc_en) w_slot <= alloc_id;
      w_cnt <= (commit || drop_done) ? '0 : ram_we ? w_cnt + LEN_W'(1) : w_cnt;
      if (rd_issue) begin
        r_slot <= rd_slot;
        r_off <= rd_off + OFF_W'(1);
      end
      id_valid <= commit;
      if (commit) id_out <= w_cur;
      w_drop <= drop_done;
      r_valid <= rd_issue;
      r_last_pkt <= rd_last;
      r_byte_valid <= rd_last ? desc_q[rd_slot].last_bv : rd_issue ? '1 : '0;
      r_err <= rd_err;
      // Allocation and release never target the same slot, so one bit update per slot suffices
      for (int i = 0; i < NUM_SLOTS; i++)
        if (alloc_en && alloc_id == ID_W'(i)) free_q[i] <= 1'b0;
        else if ((drop_done && w_slot == ID_W'(i)) || (rd_last && rd_slot == ID_W'(i))) free_q[i] <= 1'b1;
      if (commit) desc_q[w_cur] <= '{committed: 1'b1, len: commit_len, last_bv: byte_valid};
      if (rd_last) desc_q[rd_slot] <= '0;
    end
  pkt_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(CLK),
    .we(ram_we),
    .waddr(waddr),
    .wdata(data_in),
    .raddr(raddr),
    .rdata(ram_q)
  );
  assign data_out = r_valid ? ram_q : '0;
`ifdef PKT_BUF_STATS_EN
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      stat_wr_pkts <= '0;
      stat_drop_pkts <= '0;
      stat_rd_pkts <= '0;
    end else begin
      stat_wr_pkts <= stat_wr_pkts + 32'(id_valid && !(&stat_wr_pkts));
      stat_drop_pkts <= stat_drop_pkts + 32'(w_drop && !(&stat_drop_pkts));
      stat_rd_pkts <= stat_rd_pkts + 32'(r_last_pkt && !(&stat_rd_pkts));
    end
`else
  assign stat_wr_pkts = '0;
  assign stat_drop_pkts = '0;
  assign stat_rd_pkts = '0;
`endif
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb_pkt_buf_ctrl: directed self-checking bench for pkt_buf_ctrl at default geometry
module tb_pkt_buf_ctrl;
`ifdef PKT_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic CLK = 1'b0, reset = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0] byte_valid = '0, r_id_in = '0, id_out, r_byte_valid;
  logic wen = 1'b0, w_last_pkt = 1'b0, ren = 1'b0;
  logic w_ready, id_valid, w_drop, r_ready, r_valid, r_last_pkt, r_err;
  logic [31:0] data_out, stat_wr_pkts, stat_drop_pkts, stat_rd_pkts;
  logic [31:0] pat [0:127];
  int n_checks = 0, n_fail = 0, n_wr = 0, n_drop = 0, n_rd = 0;
  always #5 CLK = ~CLK;
  pkt_buf_ctrl dut (
    .CLK(CLK), .reset(reset), .data_in(data_in), .byte_valid(byte_valid), .wen(wen),
    .w_last_pkt(w_last_pkt), .w_ready(w_ready), .id_out(id_out), .id_valid(id_valid),
    .w_drop(w_drop), .ren(ren), .r_id_in(r_id_in), .r_ready(r_ready), .data_out(data_out),
    .r_byte_valid(r_byte_valid), .r_valid(r_valid), .r_last_pkt(r_last_pkt), .r_err(r_err),
    .stat_wr_pkts(stat_wr_pkts), .stat_drop_pkts(stat_drop_pkts), .stat_rd_pkts(stat_rd_pkts)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic fill(input logic [31:0] base, input int len);
    for (int k = 0; k < len; k++) pat[k] = base + 32'(k);
  endtask
  // exp_id < 0 means the packet must be dropped
  task automatic write_pkt(input int len, input logic [3:0] bv, input int exp_id);
    for (int k = 0; k < len; k++) begin
      wen = 1'b1;
      data_in = pat[k];
      w_last_pkt = (k == len - 1);
      byte_valid = (k == len - 1) ? bv : 4'hf;
      if (k == 0) check("w_ready", 32'(w_ready), 1);
      cyc();
    end
    wen = 1'b0;
    w_last_pkt = 1'b0;
    if (exp_id >= 0) begin
      check("id_valid", 32'(id_valid), 1);
      check("id_out", 32'(id_out), 32'(exp_id));
      check("w_drop_idle", 32'(w_drop), 0);
      n_wr++;
    end else begin
      check("w_drop", 32'(w_drop), 1);
      check("id_valid_drop", 32'(id_valid), 0);
      n_drop++;
    end
  endtask
  task automatic read_pkt(input int id, input int len, input logic [3:0] bv);
    ren = 1'b1;
    r_id_in = 4'(id);
    check("r_ready_req", 32'(r_ready), 1);
    cyc();
    ren = 1'b0;
    for (int k = 0; k < len; k++) begin
      check($sformatf("r_valid[%0d]", k), 32'(r_valid), 1);
      check($sformatf("data_out[%0d]", k), data_out, pat[k]);
      check($sformatf("r_bv[%0d]", k), 32'(r_byte_valid), (k == len - 1) ? 32'(bv) : 32'hf);
      check($sformatf("r_last[%0d]", k), 32'(r_last_pkt), 32'(k == len - 1));
      check($sformatf("r_ready[%0d]", k), 32'(r_ready), 32'(k == len - 1));
      cyc();
    end
    check("r_valid_end", 32'(r_valid), 0);
    n_rd++;
  endtask
  task automatic check_stats();
    check("stat_wr", stat_wr_pkts, STATS ? 32'(n_wr) : 32'h0);
    check("stat_drop", stat_drop_pkts, STATS ? 32'(n_drop) : 32'h0);
    check("stat_rd", stat_rd_pkts, STATS ? 32'(n_rd) : 32'h0);
  endtask
  task automatic check_reset_outputs();
    check("rst_w_ready", 32'(w_ready), 0);
    check("rst_r_ready", 32'(r_ready), 0);
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_id_out", 32'(id_out), 0);
    check("rst_w_drop", 32'(w_drop), 0);
    check("rst_data_out", data_out, 0);
    check("rst_r_bv", 32'(r_byte_valid), 0);
    check("rst_r_valid", 32'(r_valid), 0);
    check("rst_r_last", 32'(r_last_pkt), 0);
    check("rst_r_err", 32'(r_err), 0);
    check("rst_stat_wr", stat_wr_pkts, 0);
    check("rst_stat_drop", stat_drop_pkts, 0);
    check("rst_stat_rd", stat_rd_pkts, 0);
  endtask
  initial begin
    #2;
    check_reset_outputs();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("post_rst_w_ready", 32'(w_ready), 1);
    check("post_rst_r_ready", 32'(r_ready), 1);
    cyc();
    pat[0] = 32'hdeadface;
    pat[1] = 32'h01020304;
    pat[2] = 32'hcafef00d;
    write_pkt(3, 4'h3, 0);
    cyc();
    check("id_valid_pulse", 32'(id_valid), 0);
    read_pkt(0, 3, 4'h3);
    for (int i = 0; i < 16; i++) begin
      pat[0] = 32'h1000_0000 + 32'(i);
      write_pkt(1, 4'hf, i);
    end
    check("w_ready_full", 32'(w_ready), 0);
    pat[0] = 32'h1000_0005;
    read_pkt(5, 1, 4'hf);
    check("w_ready_freed", 32'(w_ready), 1);
    pat[0] = 32'h2000_0005;
    write_pkt(1, 4'hf, 5);
    for (int i = 0; i < 16; i++) begin
      pat[0] = (i == 5) ? 32'h2000_0005 : 32'h1000_0000 + 32'(i);
      read_pkt(i, 1, 4'hf);
    end
    fill(32'h3000_0000, 65);
    write_pkt(65, 4'hf, -1);
    pat[0] = 32'h4000_0000;
    write_pkt(1, 4'hf, 0);
    read_pkt(0, 1, 4'hf);
    fill(32'h3100_0000, 67);
    write_pkt(67, 4'hf, -1);
    fill(32'h5000_0000, 64);
    write_pkt(64, 4'h1, 0);
    read_pkt(0, 64, 4'h1);
    ren = 1'b1;
    r_id_in = 4'd7;
    cyc();
    ren = 1'b0;
    check("r_err", 32'(r_err), 1);
    check("r_valid_err", 32'(r_valid), 0);
    cyc();
    check("r_err_pulse", 32'(r_err), 0);
    check("r_valid_err2", 32'(r_valid), 0);
    pat[0] = 32'h6000_0000;
    write_pkt(1, 4'hf, 0);
    ren = 1'b1;
    r_id_in = 4'd0;
    wen = 1'b1;
    data_in = 32'h7000_0000;
    byte_valid = 4'hf;
    w_last_pkt = 1'b0;
    cyc();
    ren = 1'b0;
    check("ovl_r_valid", 32'(r_valid), 1);
    check("ovl_data", data_out, 32'h6000_0000);
    check("ovl_r_last", 32'(r_last_pkt), 1);
    data_in = 32'h7000_0001;
    byte_valid = 4'h7;
    w_last_pkt = 1'b1;
    cyc();
    wen = 1'b0;
    w_last_pkt = 1'b0;
    check("ovl_id_valid", 32'(id_valid), 1);
    check("ovl_id_out", 32'(id_out), 1);
    n_wr++;
    n_rd++;
    pat[0] = 32'h8000_0000;
    write_pkt(1, 4'hf, 0);
    ren = 1'b1;
    r_id_in = 4'd1;
    cyc();
    r_id_in = 4'd0;
    check("b2b_data0", data_out, 32'h7000_0000);
    check("b2b_busy", 32'(r_ready), 0);
    cyc();
    check("b2b_data1", data_out, 32'h7000_0001);
    check("b2b_bv", 32'(r_byte_valid), 32'h7);
    check("b2b_last", 32'(r_last_pkt), 1);
    check("b2b_ready", 32'(r_ready), 1);
    cyc();
    ren = 1'b0;
    check("b2b_valid2", 32'(r_valid), 1);
    check("b2b_data2", data_out, 32'h8000_0000);
    check("b2b_last2", 32'(r_last_pkt), 1);
    n_rd += 2;
    cyc();
    cyc();
    check_stats();
    fill(32'h9000_0000, 11);
    for (int k = 0; k < 10; k++) begin
      wen = 1'b1;
      data_in = pat[k];
      byte_valid = 4'hf;
      cyc();
    end
    data_in = pat[10];
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    cyc();
    wen = 1'b0;
    reset = 1'b1;
    #1;
    check("rel_w_ready", 32'(w_ready), 1);
    check("rel_r_ready", 32'(r_ready), 1);
    check("rel_stat_wr", stat_wr_pkts, 0);
    pat[0] = 32'ha000_0000;
    write_pkt(1, 4'hf, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
